// File: rtl/fx3_bus_in_path_pkg.sv
// Shared constants for the FX3 slave-FIFO read path.
// COMMAND_LENGTH is the project-wide count of leading command words.
package fx3_bus_in_path_pkg;

    localparam int COMMAND_LENGTH = 4;

    localparam logic FX3_ASSERT   = 1'b0;
    localparam logic FX3_DEASSERT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DMA = 3'd1,
        ST_READ     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic logic [8:0] sat_inc(
        input logic [8:0] v,
        input logic [8:0] lim
    );
        return (v >= lim) ? v : v + 9'd1;
    endfunction

endpackage

// File: rtl/fx3_rd_latency_pipe.sv
// Delay line carrying read-issued tags across the FX3 read latency.
// empty is high when no issued read is still in flight.
module fx3_rd_latency_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_tag,
    output logic out_tag,
    output logic empty
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | DEPTH'(in_tag);
        end
    end

    assign out_tag = sr[DEPTH-1];
    assign empty   = ~|sr;

endmodule

// File: rtl/fx3_bus_in_path.sv
// FX3 GPIF-II slave-FIFO read engine: one USB packet per request.
// Define FX3_IN_FLOW_CNTRL_EN to gate reads past the header on i_read_flow_cntrl.
module fx3_bus_in_path
    import fx3_bus_in_path_pkg::*;
#(
    parameter int         MAX_PACKET_WORDS = 256,
    parameter int         READ_LATENCY     = 2,
    parameter logic [1:0] IN_SOCKET        = 2'b00,
    parameter int         HEADER_WORDS     = COMMAND_LENGTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read_fx3_packet,
    input  logic        i_read_flow_cntrl,
    output logic        o_read_fx3_finished,
    output logic [31:0] o_data,
    output logic        o_data_valid,
    output logic [8:0]  o_packet_words,
    input  logic        i_fx3_dma_rdy,
    input  logic [31:0] i_fx3_data,
    output logic        o_fx3_slcs_n,
    output logic        o_fx3_sloe_n,
    output logic        o_fx3_slrd_n,
    output logic [1:0]  o_fx3_addr
);

    localparam logic [8:0] MAX9 = 9'(MAX_PACKET_WORDS);
    localparam logic [8:0] HDR9 = 9'(HEADER_WORDS);

    state_t      state;
    logic        dma_rdy_q;
    logic [31:0] data_q;
    logic        valid_q;
    logic [8:0]  issued;
    logic [8:0]  next_issued;
    logic [8:0]  words;
    logic        aborted;
    logic        gate;
    logic        issue;
    logic        tag_out;
    logic        pipe_empty;

`ifdef FX3_IN_FLOW_CNTRL_EN
    assign gate = (issued < HDR9) || i_read_flow_cntrl;
`else
    logic unused_flow;
    assign unused_flow = i_read_flow_cntrl ^ (issued < HDR9);
    assign gate        = 1'b1;
`endif

    // Strobe must follow this cycle's request and flags, so it is decoded live.
    assign issue = (state == ST_READ) && (issued < MAX9) &&
                   dma_rdy_q && i_read_fx3_packet && gate;

    assign next_issued  = issued + 9'(issue);
    assign o_fx3_slrd_n = issue ? FX3_ASSERT : FX3_DEASSERT;

    fx3_rd_latency_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .in_tag (issue),
        .out_tag(tag_out),
        .empty  (pipe_empty)
    );

    // Input capture stage; the valid tag is re-timed to line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rdy_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            dma_rdy_q <= i_fx3_dma_rdy;
            data_q    <= i_fx3_data;
            valid_q   <= tag_out;
        end
    end

    assign o_data         = data_q;
    assign o_data_valid   = valid_q;
    assign o_packet_words = words;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            words <= '0;
        end else if (state == ST_IDLE && i_read_fx3_packet) begin
            words <= '0;
        end else if (valid_q) begin
            words <= sat_inc(words, MAX9);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_IDLE;
            issued              <= '0;
            aborted             <= 1'b0;
            o_read_fx3_finished <= 1'b0;
            o_fx3_slcs_n        <= FX3_DEASSERT;
            o_fx3_sloe_n        <= FX3_DEASSERT;
            o_fx3_addr          <= 2'b00;
        end else begin
            issued <= next_issued;
            unique case (state)
                ST_IDLE: begin
                    issued              <= '0;
                    aborted             <= 1'b0;
                    o_read_fx3_finished <= 1'b0;
                    if (i_read_fx3_packet) begin
                        state        <= ST_WAIT_DMA;
                        o_fx3_slcs_n <= FX3_ASSERT;
                        o_fx3_sloe_n <= FX3_ASSERT;
                        o_fx3_addr   <= IN_SOCKET;
                    end
                end
                ST_WAIT_DMA: begin
                    if (!i_read_fx3_packet) begin
                        state        <= ST_IDLE;
                        o_fx3_slcs_n <= FX3_DEASSERT;
                        o_fx3_sloe_n <= FX3_DEASSERT;
                        o_fx3_addr   <= 2'b00;
                    end else if (dma_rdy_q) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!i_read_fx3_packet) begin
                        state   <= ST_DRAIN;
                        aborted <= 1'b1;
                    end else if (next_issued == MAX9 || !dma_rdy_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        o_fx3_slcs_n <= FX3_DEASSERT;
                        o_fx3_sloe_n <= FX3_DEASSERT;
                        o_fx3_addr   <= 2'b00;
                        if (aborted || !i_read_fx3_packet) begin
                            state <= ST_IDLE;
                        end else begin
                            state               <= ST_DONE;
                            o_read_fx3_finished <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!i_read_fx3_packet) begin
                        state               <= ST_IDLE;
                        o_read_fx3_finished <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
